// File: rtl/irrigacao_multizona_pkg.sv
// Shared types and helpers for the multi-zone irrigation controller:
// state encoding, tank sensor plausibility check and width helpers.
package irrigacao_pkg;

  typedef enum logic [2:0] {
    OCIOSO,
    ENCHENDO,
    ASPERSAO,
    GOTEJAMENTO,
    AGRO,
    LIMPEZA,
    SAIDA_LIMPEZA,
    ERRO
  } estado_t;

  // A wetted upper sensor above a dry lower one is physically impossible.
  function automatic logic sensor_fault(input logic h, input logic m, input logic l);
    return (h & ~m) | (m & ~l) | (h & ~l);
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  function automatic int unsigned idx_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                            input int unsigned c, input int unsigned d,
                                            input int unsigned e);
    return $clog2(max_u(max_u(max_u(a, b), max_u(c, d)), e)) + 1;
  endfunction

  function automatic logic [7:0] state_flags(input estado_t s);
    logic [7:0] f;
    f = '0;
    case (s)
      OCIOSO:        f[7] = 1'b1;
      ENCHENDO:      f[6] = 1'b1;
      ASPERSAO:      f[5] = 1'b1;
      GOTEJAMENTO:   f[4] = 1'b1;
      AGRO:          f[3] = 1'b1;
      LIMPEZA:       f[2] = 1'b1;
      SAIDA_LIMPEZA: f[1] = 1'b1;
      ERRO:          f[0] = 1'b1;
      default:       f    = '0;
    endcase
    return f;
  endfunction

  function automatic logic drives_zone(input estado_t s);
    return (s == ASPERSAO) || (s == GOTEJAMENTO) || (s == AGRO) || (s == LIMPEZA);
  endfunction

endpackage

// File: rtl/irrigacao_multizona_arbitro_rr.sv
// Round-robin zone arbiter: picks the first requesting zone after the pointer,
// skipping sprinkler zones while it is hot.
module arbitro_rr
  import irrigacao_pkg::*;
#(
  parameter int unsigned N_ZONES = 4,
  parameter int unsigned ZW      = idx_width(N_ZONES)
) (
  input  logic [N_ZONES-1:0] i_req,
  input  logic [ZW-1:0]      i_ptr,
  input  logic [N_ZONES-1:0] i_modo,
  input  logic               i_T,
  output logic [ZW-1:0]      o_idx,
  output logic               o_valid
);

  logic [N_ZONES-1:0] w_elig;

  assign w_elig = i_req & (i_T ? ~i_modo : '1);

  // Scan from farthest to nearest so the zone closest after the pointer wins.
  always_comb begin
    int unsigned j;
    o_idx   = '0;
    o_valid = 1'b0;
    j       = 0;
    for (int unsigned k = N_ZONES; k >= 1; k--) begin
      j = (32'(i_ptr) + k) % N_ZONES;
      if (w_elig[j]) begin
        o_idx   = ZW'(j);
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irrigacao_multizona.sv
// Control core for one shared tank feeding N_ZONES irrigation zones: fill,
// timed sprinkler/drip cycles, agrochemical dosing with mandatory flush, fault handling.
module irrigacao_multizona
  import irrigacao_pkg::*;
#(
  parameter int unsigned N_ZONES      = 4,
  parameter int unsigned ASP_CYCLES   = 50,
  parameter int unsigned GOT_CYCLES   = 100,
  parameter int unsigned AGRO_CYCLES  = 30,
  parameter int unsigned CLEAN_CYCLES = 20,
  parameter int unsigned FILL_TIMEOUT = 200,
  localparam int unsigned ZW          = idx_width(N_ZONES)
) (
  input  logic               i_Clock,
  input  logic               i_Reset,
  input  logic               i_H,
  input  logic               i_M,
  input  logic               i_L,
  input  logic [N_ZONES-1:0] i_Us,
  input  logic [N_ZONES-1:0] i_Modo,
  input  logic               i_T,
  input  logic               i_Ag,
  input  logic               i_Ack_Erro,
  output logic               o_Ve,
  output logic               o_Bs,
  output logic               o_Bs_Ag,
  output logic [N_ZONES-1:0] o_Vz,
  output logic [ZW-1:0]      o_Zona,
  output logic               o_Al,
  output logic               o_E,
  output logic               o_S_Ocioso,
  output logic               o_S_Enchendo,
  output logic               o_S_Aspersao,
  output logic               o_S_Gotejamento,
  output logic               o_S_Agro,
  output logic               o_S_Limpeza,
  output logic               o_S_SaidaLimpeza,
  output logic               o_S_Erro
);

  localparam int unsigned CW = cnt_width(ASP_CYCLES, GOT_CYCLES, AGRO_CYCLES,
                                         CLEAN_CYCLES, FILL_TIMEOUT);
  localparam logic [CW-1:0] ASP_LAST   = CW'(ASP_CYCLES - 1);
  localparam logic [CW-1:0] GOT_LAST   = CW'(GOT_CYCLES - 1);
  localparam logic [CW-1:0] AGRO_LAST  = CW'(AGRO_CYCLES - 1);
  localparam logic [CW-1:0] CLEAN_LAST = CW'(CLEAN_CYCLES - 1);
  localparam logic [CW-1:0] FILL_LAST  = CW'(FILL_TIMEOUT - 1);
  localparam logic [ZW-1:0] PTR_RESET  = ZW'(N_ZONES - 1);

  estado_t            r_state;
  estado_t            w_next;
  logic [CW-1:0]      r_cnt;
  logic               r_ag_pend;
  logic [ZW-1:0]      r_zona;
  logic [ZW-1:0]      r_ptr;
  logic [ZW-1:0]      w_next_zona;
  logic [ZW-1:0]      w_grant_idx;
  logic               w_grant_valid;
  logic               w_grant_take;
  logic               w_fault;
  logic [N_ZONES-1:0] w_vz_next;

  logic               r_ve;
  logic               r_bs;
  logic               r_bs_ag;
  logic               r_al;
  logic               r_e;
  logic [N_ZONES-1:0] r_vz;
  logic [7:0]         r_flags;

  assign w_fault = sensor_fault(i_H, i_M, i_L);

  arbitro_rr #(
    .N_ZONES(N_ZONES),
    .ZW     (ZW)
  ) u_arbitro (
    .i_req  (i_Us),
    .i_ptr  (r_ptr),
    .i_modo (i_Modo),
    .i_T    (i_T),
    .o_idx  (w_grant_idx),
    .o_valid(w_grant_valid)
  );

  // Priority inside each state: fault > low tank > cycle end > soil/temperature abort.
  always_comb begin
    w_next       = r_state;
    w_next_zona  = r_zona;
    w_grant_take = 1'b0;
    if (w_fault) begin
      w_next = ERRO;
    end else begin
      case (r_state)
        OCIOSO: begin
          if (!i_L) begin
            w_next = ENCHENDO;
          end else if (w_grant_valid) begin
            w_grant_take = 1'b1;
            w_next_zona  = w_grant_idx;
            if (r_ag_pend)                w_next = AGRO;
            else if (i_Modo[w_grant_idx]) w_next = ASPERSAO;
            else                          w_next = GOTEJAMENTO;
          end
        end
        ENCHENDO: begin
          if (i_H)                     w_next = OCIOSO;
          else if (r_cnt == FILL_LAST) w_next = ERRO;
        end
        ASPERSAO: begin
          if (!i_L)                                               w_next = ENCHENDO;
          else if ((r_cnt == ASP_LAST) || !i_Us[r_zona] || i_T)   w_next = OCIOSO;
        end
        GOTEJAMENTO: begin
          if (!i_L)                                      w_next = ENCHENDO;
          else if ((r_cnt == GOT_LAST) || !i_Us[r_zona]) w_next = OCIOSO;
        end
        AGRO: begin
          if ((r_cnt == AGRO_LAST) || !i_L) w_next = LIMPEZA;
        end
        LIMPEZA: begin
          if (!i_L)                     w_next = ERRO;
          else if (r_cnt == CLEAN_LAST) w_next = SAIDA_LIMPEZA;
        end
        SAIDA_LIMPEZA: w_next = OCIOSO;
        ERRO: begin
          if (i_Ack_Erro) w_next = OCIOSO;
        end
        default: w_next = OCIOSO;
      endcase
    end
  end

  always_comb begin
    w_vz_next = '0;
    if (drives_zone(w_next)) w_vz_next[w_next_zona] = 1'b1;
  end

  // Outputs are decoded from the next state so they register alongside it.
  always_ff @(posedge i_Clock) begin
    if (!i_Reset) begin
      r_state   <= OCIOSO;
      r_cnt     <= '0;
      r_ag_pend <= 1'b0;
      r_zona    <= '0;
      r_ptr     <= PTR_RESET;
      r_ve      <= 1'b0;
      r_bs      <= 1'b0;
      r_bs_ag   <= 1'b0;
      r_al      <= 1'b0;
      r_e       <= 1'b0;
      r_vz      <= '0;
      r_flags   <= 8'b1000_0000;
    end else begin
      r_state <= w_next;
      r_zona  <= w_next_zona;
      if (w_grant_take) r_ptr <= w_grant_idx;

      if (w_next != r_state) r_cnt <= '0;
      else if (r_cnt != '1)  r_cnt <= r_cnt + 1'b1;

      if ((r_state == LIMPEZA) && (w_next == SAIDA_LIMPEZA)) r_ag_pend <= 1'b0;
      else if (i_Ag && (r_state != ERRO))                      r_ag_pend <= 1'b1;

      r_ve    <= (w_next == ENCHENDO);
      r_bs    <= drives_zone(w_next);
      r_bs_ag <= (w_next == AGRO);
      r_al    <= ((w_next == ENCHENDO) && !i_L) || (w_next == ERRO);
      r_e     <= (w_next == ERRO);
      r_vz    <= w_vz_next;
      r_flags <= state_flags(w_next);
    end
  end

  assign o_Ve             = r_ve;
  assign o_Bs             = r_bs;
  assign o_Bs_Ag          = r_bs_ag;
  assign o_Vz             = r_vz;
  assign o_Zona           = r_zona;
  assign o_Al             = r_al;
  assign o_E              = r_e;
  assign o_S_Ocioso       = r_flags[7];
  assign o_S_Enchendo     = r_flags[6];
  assign o_S_Aspersao     = r_flags[5];
  assign o_S_Gotejamento  = r_flags[4];
  assign o_S_Agro         = r_flags[3];
  assign o_S_Limpeza      = r_flags[2];
  assign o_S_SaidaLimpeza = r_flags[1];
  assign o_S_Erro         = r_flags[0];

endmodule
